// File: rtl/d_stage_pkg.sv
// Shared decode-stage constants: base opcodes, immediate format codes and buffer types.
package d_stage_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] IMM_S     = 3'd0;
    localparam logic [2:0] IMM_B     = 3'd1;
    localparam logic [2:0] IMM_U     = 3'd2;
    localparam logic [2:0] IMM_J     = 3'd3;
    localparam logic [2:0] IMM_I     = 3'd4;
    localparam logic [2:0] IMM_SHIFT = 3'd5;
    localparam logic [2:0] IMM_CSR   = 3'd6;
    localparam logic [2:0] IMM_NONE  = 3'd7;

    localparam logic [11:0] CSR_TOHOST = 12'h51E;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Width-independent decoded fields carried alongside the immediate.
    typedef struct packed {
        logic [2:0] imm_sel;
        logic       illegal;
        logic       csr_tohost;
    } dec_t;

endpackage

// File: rtl/d_stage_imm_gen.sv
// Combinational immediate classifier/extender for one 32-bit instruction.
module d_stage_imm_gen
    import d_stage_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter logic [11:0] TOHOST_ADDR = CSR_TOHOST
) (
    input  logic [31:0]     inst_i,
    output logic [2:0]      imm_sel_c,
    output logic [XLEN-1:0] imm_c,
    output logic            illegal_c,
    output logic            csr_tohost_c
);

    localparam int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5;

    logic [6:0] opc;
    logic [2:0] funct3;
    logic       is_shift;

    assign opc      = inst_i[6:0];
    assign funct3   = inst_i[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        sext32 = XLEN'($signed(v));
    endfunction

    // Format classification; word-sized ops only exist on RV64.
    always_comb begin
        imm_sel_c    = IMM_NONE;
        illegal_c    = 1'b0;
        csr_tohost_c = 1'b0;
        case (opc)
            OPC_LOAD, OPC_JALR: imm_sel_c = IMM_I;
            OPC_OP_IMM:         imm_sel_c = is_shift ? IMM_SHIFT : IMM_I;
            OPC_OP_IMM_32: begin
                imm_sel_c = is_shift ? IMM_SHIFT : IMM_I;
                illegal_c = (XLEN != 64);
            end
            OPC_STORE:          imm_sel_c = IMM_S;
            OPC_BRANCH:         imm_sel_c = IMM_B;
            OPC_LUI, OPC_AUIPC: imm_sel_c = IMM_U;
            OPC_JAL:            imm_sel_c = IMM_J;
            OPC_OP, OPC_MISC_MEM: imm_sel_c = IMM_NONE;
            OPC_OP_32:          illegal_c = (XLEN != 64);
            OPC_SYSTEM: begin
                imm_sel_c    = funct3[2] ? IMM_CSR : IMM_NONE;
                csr_tohost_c = (funct3 != 3'b000) && (inst_i[31:20] == TOHOST_ADDR);
            end
            default:            illegal_c = 1'b1;
        endcase
    end

    always_comb begin
        imm_c = '0;
        case (imm_sel_c)
            IMM_S:     imm_c = sext32({{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]});
            IMM_B:     imm_c = sext32({{19{inst_i[31]}}, inst_i[31], inst_i[7],
                                       inst_i[30:25], inst_i[11:8], 1'b0});
            IMM_U:     imm_c = sext32({inst_i[31:12], 12'b0});
            IMM_J:     imm_c = sext32({{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                                       inst_i[20], inst_i[30:21], 1'b0});
            IMM_I:     imm_c = sext32({{20{inst_i[31]}}, inst_i[31:20]});
            IMM_SHIFT: imm_c = XLEN'(inst_i[20 +: SHAMT_W]);
            IMM_CSR:   imm_c = XLEN'(inst_i[19:15]);
            default:   imm_c = '0;
        endcase
    end

endmodule

// File: rtl/d_stage_imm_decode.sv
// Decode-stage immediate unit: decodes at the input, then holds results in a
// two-entry skid buffer (main + skid) toward execute.
module d_stage_imm_decode
    import d_stage_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter logic [11:0] TOHOST_ADDR = CSR_TOHOST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_sel,
    output logic            out_illegal,
    output logic            out_csr_tohost
);

    dec_t            in_dec;
    logic [XLEN-1:0] in_imm;

    d_stage_imm_gen #(
        .XLEN        (XLEN),
        .TOHOST_ADDR (TOHOST_ADDR)
    ) u_imm_gen (
        .inst_i       (in_inst),
        .imm_sel_c    (in_dec.imm_sel),
        .imm_c        (in_imm),
        .illegal_c    (in_dec.illegal),
        .csr_tohost_c (in_dec.csr_tohost)
    );

    occ_e            occ_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [31:0]     main_inst_q, skid_inst_q;
    logic [XLEN-1:0] main_pc_q,   skid_pc_q;
    logic [XLEN-1:0] main_imm_q,  skid_imm_q;
    dec_t            main_dec_q,  skid_dec_q;

    logic accept, consume;
    logic load_main_in, load_skid_in, load_main_skid;

    assign accept  = in_valid && in_ready_q && !flush;
    assign consume = out_valid_q && out_ready && !flush;

    assign load_main_in   = accept && ((occ_q == OCC_EMPTY) || ((occ_q == OCC_ONE) && consume));
    assign load_skid_in   = accept && (occ_q == OCC_ONE) && !consume;
    assign load_main_skid = consume && (occ_q == OCC_FULL);

    // Occupancy FSM; ready/valid are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_q       <= OCC_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        occ_q       <= OCC_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && !consume) begin
                        occ_q      <= OCC_FULL;
                        in_ready_q <= 1'b0;
                    end else if (!accept && consume) begin
                        occ_q       <= OCC_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                OCC_FULL: begin
                    if (consume) begin
                        occ_q      <= OCC_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    occ_q       <= OCC_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Payload registers hold their value unless loaded, keeping the head stable under stall.
    always_ff @(posedge clk) begin
        if (load_main_in) begin
            main_inst_q <= in_inst;
            main_pc_q   <= in_pc;
            main_imm_q  <= in_imm;
            main_dec_q  <= in_dec;
        end else if (load_main_skid) begin
            main_inst_q <= skid_inst_q;
            main_pc_q   <= skid_pc_q;
            main_imm_q  <= skid_imm_q;
            main_dec_q  <= skid_dec_q;
        end
        if (load_skid_in) begin
            skid_inst_q <= in_inst;
            skid_pc_q   <= in_pc;
            skid_imm_q  <= in_imm;
            skid_dec_q  <= in_dec;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_inst       = out_valid_q ? main_inst_q : '0;
    assign out_pc         = out_valid_q ? main_pc_q : '0;
    assign out_imm        = out_valid_q ? main_imm_q : '0;
    assign out_imm_sel    = out_valid_q ? main_dec_q.imm_sel : 3'd0;
    assign out_illegal    = out_valid_q && main_dec_q.illegal;
    assign out_csr_tohost = out_valid_q && main_dec_q.csr_tohost;

endmodule

// File: doc/d_stage_imm_decode.md
# d_stage_imm_decode

Parametrised decode-stage immediate unit for the pipelined RISC-V core. It classifies each fetched instruction's immediate format and produces the fully extended XLEN-wide immediate. The immediate, its format code and pass-through fields are registered into a two-entry skid buffer toward the execute stage. The block sits between the fetch/decode boundary and the D/X pipeline register consumers, with valid/ready handshakes on both sides and a pipeline flush.

## Interface

Parameters:
- XLEN, 32: datapath width; legal values 32 and 64.
- TOHOST_ADDR, 12'h51E: CSR address flagged as the tohost CSR.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill all buffered entries and the current input.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  block can accept an instruction this cycle.
- in_inst  in  32  raw instruction.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute stage consumes the head entry.
- out_inst  out  32  registered instruction.
- out_pc  out  XLEN  registered PC.
- out_imm  out  XLEN  extended immediate.
- out_imm_sel  out  3  immediate format code.
- out_illegal  out  1  opcode not recognised.
- out_csr_tohost  out  1  CSR instruction addressing TOHOST_ADDR.

## Operation

- Format codes:
  - 0 S (store)
  - 1 B (branch)
  - 2 U (LUI/AUIPC)
  - 3 J (JAL)
  - 4 I (loads, JALR, ARI-I non-shift)
  - 5 shift (ARI-I with funct3 001/101)
  - 6 CSR zimm
  - 7 none (R-type, FENCE, illegal)
- JALR is decoded as I, not J.
- Sign extension: S, B, U, J and I are sign-extended from inst[31] to XLEN. U places inst[31:12] at bits 31:12, with zeros below.
- Shift amount width depends on XLEN:
  - XLEN=32: inst[24:20].
  - XLEN=64: inst[25:20].
  - The result is zero-extended; funct7 bits never appear in out_imm.
- CSR immediate: inst[19:15], zero-extended.
- out_csr_tohost = 1 when opcode is CSR and inst[31:20] equals TOHOST_ADDR.
- Format 7 gives out_imm = 0.
- out_illegal = 1 for any opcode outside the RV32I/RV64I base set plus SYSTEM.
- Buffer: main entry (the head, driving out_*) plus one skid entry.
  - in_ready = !skid_valid. It is a pure register output, with no combinational path from out_ready.
  - Accept when in_valid && in_ready && !flush.
  - Accepted data goes to the main entry if the main entry is empty or being consumed this cycle; otherwise it goes to skid.
  - On consumption, skid moves to main.
- Order is strictly FIFO; no entry is duplicated or dropped.
- Occupancy states and transitions:
  - EMPTY → ONE on accept.
  - ONE → FULL on accept without consume.
  - FULL → ONE on consume.
  - ONE → EMPTY on consume without accept.
- Simultaneous accept and consume in ONE stays in ONE.
- Simultaneous events in FULL: consume without accept is FULL → ONE, with skid moving to main. Accept cannot occur in FULL, because in_ready is low there.
- Flush has priority over everything. Both valids clear next cycle, and an input offered during a flush cycle is dropped.
- Reset: all out_* = 0, out_valid = 0, in_ready = 1, and both entries are invalid. Data registers need not be reset, but outputs are gated to 0 while invalid.
- Reset asserted mid-transfer: identical to flush; no entry survives.

## Timing

- Latency: 1 cycle from accept to out_valid with the decoded fields.
- Steady-state throughput: 1 instruction/cycle when out_ready is held high.
- After out_ready falls, at most two further instructions are accepted; in_ready drops the cycle after the skid fills.
- in_ready returns high the cycle after a consume from FULL.
- After flush or reset deasserts: in_ready = 1 and out_valid = 0 in that same cycle.
- out_* are stable while out_valid && !out_ready.

## Structure

- Shared package d_stage_pkg holds:
  - OPC_* opcode constants.
  - IMM_S..IMM_NONE format codes (3-bit).
  - CSR_TOHOST default.
- Combinational sub-module d_stage_imm_gen (inst → imm_sel, imm, illegal, csr_tohost; parameter XLEN). It is instantiated once, at the input, so the buffer stores decoded results.
- The top level contains only the skid buffer and flush/reset control.

## Test plan

- addi x1,x0,-1 (0xFFF00093), XLEN=32, out_ready=1 → next cycle out_valid=1, sel=4, imm=0xFFFFFFFF, illegal=0.
- slli 0x00309093 then srai 0x4030D093 on back-to-back cycles → sel=5, imm=3 for both, on consecutive cycles.
- beq x0,x0,-4 (0xFE000EE3) → sel=1, imm=0xFFFFFFFC; inst 0x0000007F → sel=7, imm=0, illegal=1.
- in_valid every cycle, out_ready low for 3 cycles → two instructions accepted, in_ready=0 from the third cycle; on release both drain in order with no loss or duplicates.
- flush asserted while FULL with in_valid=1 → next cycle out_valid=0 and in_ready=1; the flushed and offered instructions never appear at the output.
- XLEN=64: lui 0x800000B7 → sel=2, imm=0xFFFFFFFF80000000; csrwi 0x51E05073 → sel=6, imm=0, csr_tohost=1.
